// File: rtl/cmd_dispatch.sv
// Command dispatcher between UART_wrapper and the actuator side: accept, issue, watch, respond.
// Optional macro CMD_DISPATCH_NACK_EN: illegal opcodes are answered with a 5A status byte.
module cmd_dispatch #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [15:0] VALID_OPC_MASK = 16'h0054,
   parameter logic [7:0]  ACK_BYTE       = 8'hA5,
   parameter logic [7:0]  TMO_BYTE       = 8'hEE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cmd,
   input  logic        cmd_rdy,
   output logic        clr_cmd_rdy,
   output logic        op_vld,
   output logic [3:0]  op_code,
   output logic [11:0] op_arg,
   input  logic        op_done,
   output logic [7:0]  resp,
   output logic        trmt,
   input  logic        tx_done,
   output logic        busy,
   output logic        err_tmo
);

   localparam int unsigned   TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMR_MAX   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    NACK_BYTE = 8'h5A;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      RESP,
      WAIT_TX
   } state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer;
   logic          opc_legal;
   logic          tmr_expired;
   logic          accept;
   logic          latch_cmd;
   logic          resp_ld;
   logic [7:0]    resp_nxt;

   assign opc_legal   = VALID_OPC_MASK[cmd[15:12]];
   assign tmr_expired = (timer == TMR_MAX);
   assign busy        = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      op_vld    = 1'b0;
      trmt      = 1'b0;
      err_tmo   = 1'b0;
      accept    = 1'b0;
      latch_cmd = 1'b0;
      resp_ld   = 1'b0;
      resp_nxt  = resp;
      unique case (state)
         IDLE: begin
            if (cmd_rdy) begin
               accept = 1'b1;
               if (opc_legal) begin
                  latch_cmd = 1'b1;
                  state_nxt = ISSUE;
               end else begin
`ifdef CMD_DISPATCH_NACK_EN
                  latch_cmd = 1'b1;
                  resp_ld   = 1'b1;
                  resp_nxt  = NACK_BYTE;
                  state_nxt = RESP;
`else
                  state_nxt = IDLE;
`endif
               end
            end
         end
         ISSUE: begin
            op_vld    = 1'b1;
            state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            // Completion beats the watchdog when both land on the same edge.
            if (op_done) begin
               resp_ld   = 1'b1;
               resp_nxt  = ACK_BYTE;
               state_nxt = RESP;
            end else if (tmr_expired) begin
               err_tmo   = 1'b1;
               resp_ld   = 1'b1;
               resp_nxt  = TMO_BYTE;
               state_nxt = RESP;
            end
         end
         RESP: begin
            trmt      = 1'b1;
            state_nxt = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Watchdog saturates at its terminal count instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (state == ISSUE) begin
         timer <= '0;
      end else if (state == WAIT_DONE && !tmr_expired) begin
         timer <= timer + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cmd_rdy <= 1'b0;
         op_code     <= 4'h0;
         op_arg      <= 12'h000;
         resp        <= 8'h00;
      end else begin
         clr_cmd_rdy <= accept;
         if (latch_cmd) begin
            op_code <= cmd[15:12];
            op_arg  <= cmd[11:0];
         end
         if (resp_ld) resp <= resp_nxt;
      end
   end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch with a 50-cycle watchdog; outputs sampled 1ns after each rising edge.
module tb_cmd_dispatch;

   localparam int unsigned TMO = 50;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        op_vld;
   logic [3:0]  op_code;
   logic [11:0] op_arg;
   logic        op_done;
   logic [7:0]  resp;
   logic        trmt;
   logic        tx_done;
   logic        busy;
   logic        err_tmo;

   int n_checks = 0;
   int n_pass   = 0;

   cmd_dispatch #(
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (cmd),
      .cmd_rdy    (cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy),
      .op_vld     (op_vld),
      .op_code    (op_code),
      .op_arg     (op_arg),
      .op_done    (op_done),
      .resp       (resp),
      .trmt       (trmt),
      .tx_done    (tx_done),
      .busy       (busy),
      .err_tmo    (err_tmo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [36:0] all_outs();
      return {clr_cmd_rdy, op_vld, trmt, busy, err_tmo, resp, op_code, op_arg};
   endfunction

   task automatic test_reset();
      rst_n   = 1'b0;
      cmd     = 16'h0000;
      cmd_rdy = 1'b0;
      op_done = 1'b0;
      tx_done = 1'b0;
      #23;
      n_checks++;
      if (all_outs() !== 37'd0) $display("FAIL reset_asserted: got %h want 0", all_outs());
      else n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (all_outs() !== 37'd0) $display("FAIL reset_idle[%0d]: got %h want 0", i, all_outs());
         else n_pass++;
      end
   endtask

   task automatic test_valid_op();
      int bad;
      cmd     = 16'h2ABC;
      cmd_rdy = 1'b1;
      tick();
      n_checks++;
      if ({clr_cmd_rdy, op_vld, busy} !== 3'b111)
         $display("FAIL valid_issue: got clr/vld/busy=%b want 111", {clr_cmd_rdy, op_vld, busy});
      else n_pass++;
      n_checks++;
      if ({op_code, op_arg} !== 16'h2ABC) $display("FAIL valid_latch: got %h want 2abc", {op_code, op_arg});
      else n_pass++;
      cmd_rdy = 1'b0;
      bad = 0;
      for (int i = 1; i <= 19; i++) begin
         tick();
         if ({clr_cmd_rdy, op_vld, trmt, err_tmo} !== 4'b0000 || busy !== 1'b1) bad++;
      end
      tick();
      op_done = 1'b1;
      n_checks++;
      if (bad !== 0) $display("FAIL valid_wait: got %0d bad cycles want 0", bad);
      else n_pass++;
      tick();
      op_done = 1'b0;
      n_checks++;
      if ({trmt, busy, err_tmo, resp} !== {3'b110, 8'hA5})
         $display("FAIL valid_resp: got trmt/busy/tmo/resp=%b %h want 110 a5", {trmt, busy, err_tmo}, resp);
      else n_pass++;
      bad = 0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (trmt !== 1'b0 || busy !== 1'b1) bad++;
      end
      tick();
      tx_done = 1'b1;
      n_checks++;
      if (bad !== 0) $display("FAIL valid_wait_tx: got %0d bad cycles want 0", bad);
      else n_pass++;
      tick();
      tx_done = 1'b0;
      n_checks++;
      if ({busy, trmt, resp} !== {2'b00, 8'hA5})
         $display("FAIL valid_idle: got busy/trmt/resp=%b %h want 00 a5", {busy, trmt}, resp);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int bad;
      cmd     = 16'h4001;
      cmd_rdy = 1'b1;
      tick();
      cmd_rdy = 1'b0;
      n_checks++;
      if (op_vld !== 1'b1) $display("FAIL tmo_issue: got op_vld=%b want 1", op_vld);
      else n_pass++;
      bad = 0;
      for (int k = 1; k < int'(TMO); k++) begin
         tick();
         if (err_tmo !== 1'b0 || trmt !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL tmo_early: got %0d early pulses want 0", bad);
      else n_pass++;
      tick();
      n_checks++;
      if ({err_tmo, trmt} !== 2'b10) $display("FAIL tmo_pulse: got err_tmo/trmt=%b want 10", {err_tmo, trmt});
      else n_pass++;
      tick();
      n_checks++;
      if ({err_tmo, trmt, resp} !== {2'b01, 8'hEE})
         $display("FAIL tmo_resp: got err_tmo/trmt/resp=%b %h want 01 ee", {err_tmo, trmt}, resp);
      else n_pass++;
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL tmo_idle: got busy=%b want 0", busy);
      else n_pass++;
   endtask

   task automatic test_tie();
      cmd     = 16'h4002;
      cmd_rdy = 1'b1;
      tick();
      cmd_rdy = 1'b0;
      for (int k = 1; k < int'(TMO); k++) tick();
      tick();
      op_done = 1'b1;
      #1;
      n_checks++;
      if (err_tmo !== 1'b0) $display("FAIL tie_err_tmo: got %b want 0", err_tmo);
      else n_pass++;
      tick();
      op_done = 1'b0;
      n_checks++;
      if ({trmt, err_tmo, resp} !== {2'b10, 8'hA5})
         $display("FAIL tie_resp: got trmt/tmo/resp=%b %h want 10 a5", {trmt, err_tmo}, resp);
      else n_pass++;
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   task automatic test_illegal();
      int bad;
      cmd     = 16'h3123;
      cmd_rdy = 1'b1;
      tick();
      cmd_rdy = 1'b0;
`ifdef CMD_DISPATCH_NACK_EN
      n_checks++;
      if ({clr_cmd_rdy, op_vld, trmt, resp} !== {3'b101, 8'h5A})
         $display("FAIL nack_resp: got clr/vld/trmt/resp=%b %h want 101 5a", {clr_cmd_rdy, op_vld, trmt}, resp);
      else n_pass++;
      n_checks++;
      if ({op_code, op_arg} !== 16'h3123) $display("FAIL nack_latch: got %h want 3123", {op_code, op_arg});
      else n_pass++;
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL nack_idle: got busy=%b want 0", busy);
      else n_pass++;
`else
      n_checks++;
      if ({clr_cmd_rdy, op_vld, trmt, busy} !== 4'b1000)
         $display("FAIL illegal_ack: got clr/vld/trmt/busy=%b want 1000", {clr_cmd_rdy, op_vld, trmt, busy});
      else n_pass++;
      n_checks++;
      if ({op_code, op_arg} !== 16'h4002) $display("FAIL illegal_hold: got %h want 4002", {op_code, op_arg});
      else n_pass++;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if ({clr_cmd_rdy, op_vld, trmt, busy} !== 4'b0000) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL illegal_quiet: got %0d active cycles want 0", bad);
      else n_pass++;
`endif
   endtask

   task automatic test_back_to_back();
      int bad;
      cmd     = 16'h2ABC;
      cmd_rdy = 1'b1;
      tick();
      cmd_rdy = 1'b0;
      tick();
      op_done = 1'b1;
      tick();
      op_done = 1'b0;
      n_checks++;
      if (trmt !== 1'b1) $display("FAIL b2b_min_latency: got trmt=%b want 1", trmt);
      else n_pass++;
      tick();
      cmd     = 16'h6FFF;
      cmd_rdy = 1'b1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (clr_cmd_rdy !== 1'b0 || busy !== 1'b1) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL b2b_hold: got %0d early accepts want 0", bad);
      else n_pass++;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n_checks++;
      if ({clr_cmd_rdy, op_vld, busy} !== 3'b000)
         $display("FAIL b2b_same_edge: got clr/vld/busy=%b want 000", {clr_cmd_rdy, op_vld, busy});
      else n_pass++;
      tick();
      cmd_rdy = 1'b0;
      n_checks++;
      if ({clr_cmd_rdy, op_vld, op_code, op_arg} !== {2'b11, 16'h6FFF})
         $display("FAIL b2b_accept: got clr/vld=%b op=%h want 11 6fff", {clr_cmd_rdy, op_vld}, {op_code, op_arg});
      else n_pass++;
      tick();
      op_done = 1'b1;
      tick();
      op_done = 1'b0;
      n_checks++;
      if ({trmt, resp} !== {1'b1, 8'hA5}) $display("FAIL b2b_resp: got trmt/resp=%b %h want 1 a5", trmt, resp);
      else n_pass++;
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   task automatic test_reset_mid();
      int trmt_cnt;
      int busy_cnt;
      cmd     = 16'h2123;
      cmd_rdy = 1'b1;
      tick();
      cmd_rdy = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (all_outs() !== 37'd0) $display("FAIL mid_reset: got %h want 0", all_outs());
      else n_pass++;
      #3;
      rst_n    = 1'b1;
      trmt_cnt = 0;
      busy_cnt = 0;
      for (int i = 0; i < int'(TMO) + 10; i++) begin
         tick();
         if (trmt === 1'b1) trmt_cnt++;
         if (busy !== 1'b0) busy_cnt++;
      end
      n_checks++;
      if ({trmt_cnt, busy_cnt} !== {32'd0, 32'd0})
         $display("FAIL mid_reset_quiet: got trmt=%0d busy=%0d want 0 0", trmt_cnt, busy_cnt);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_valid_op();
      test_timeout();
      test_tie();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
